// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle for seq_chunk_adder: operands and mode in,
// busy/done handshake and registered result out.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built from one CHUNK-bit ripple slice,
// consuming one chunk per clock, LSB chunk first.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] sum_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK:0]   chunk_sum_s;
    logic             msb_cin_s;
    logic             last_s;
    logic [WIDTH-1:0] acc_next_s;

    // Operands shift right each cycle, so the active chunk always sits in the low CHUNK bits.
    always_comb begin
        chunk_sum_s = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
        msb_cin_s   = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
        last_s      = (cnt_r == CW'(N - 1));
    end

    // Accumulator fills from the top; after N shifts it holds the whole result in place.
    generate
        if (N == 1) begin : g_single
            always_comb begin
                acc_next_s = chunk_sum_s[CHUNK-1:0];
            end
        end else begin : g_multi
            always_comb begin
                acc_next_s = {chunk_sum_s[CHUNK-1:0], acc_r[WIDTH-1:CHUNK]};
            end
        end
    endgenerate

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            sum_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub ? ~bus.cin : bus.cin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    acc_r   <= acc_next_s;
                    carry_r <= chunk_sum_s[CHUNK];
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r   <= acc_next_s;
                        cout_r  <= chunk_sum_s[CHUNK];
                        ovf_r   <= msb_cin_s ^ chunk_sum_s[CHUNK];
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (WIDTH=16, CHUNK=4): a driver queues
// arithmetic-model results, an independent monitor checks every done pulse.
module tb_seq_chunk_adder;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t hold;

    seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Plain integer arithmetic reference.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic cin);
        exp_t e;
        int   ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (a[WIDTH-1]) ? ua - 65536 : ua;
        sb = (b[WIDTH-1]) ? ub - 65536 : ub;
        if (!sub) begin
            ur = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            e.cout = (ur > 65535);
        end else begin
            ur = ua - ub - int'(cin);
            sr = sa - sb - int'(cin);
            e.cout = (ur >= 0);
        end
        e.sum = ur[WIDTH-1:0];
        e.ovf = (sr > 32767) || (sr < -32768);
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: checks every done pulse against the queue and holds outputs otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sum", 32'(bus.sum), 32'(e.sum));
                chk("cout", 32'(bus.cout), 32'(e.cout));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                chk("done_latency", 32'(cyc), 32'(e.due));
                hold = e;
            end
        end else begin
            chk("sum_hold", 32'(bus.sum), 32'(hold.sum));
            chk("cout_hold", 32'(bus.cout), 32'(hold.cout));
            chk("ovf_hold", 32'(bus.ovf), 32'(hold.ovf));
        end
        chk("busy", 32'(bus.busy), 32'(sb_q.size() != 0));
    end

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic isub, input logic icin);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy !== 1'b0) begin
            chk("busy_timeout", 32'(bus.busy), 32'd0);
        end else begin
            bus.a     = ia;
            bus.b     = ib;
            bus.sub   = isub;
            bus.cin   = icin;
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            e     = model(ia, ib, isub, icin);
            e.due = cyc + N;
            sb_q.push_back(e);
            bus.start = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        sb_q.delete();
        hold.sum  = '0;
        hold.cout = 1'b0;
        hold.ovf  = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            bus.a     = WIDTH'($urandom);
            bus.b     = WIDTH'($urandom);
            bus.sub   = 1'($urandom);
            bus.cin   = 1'($urandom);
            bus.start = 1'($urandom);
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        hold.sum  = '0;
        hold.cout = 1'b0;
        hold.ovf  = 1'b0;
        hold.due  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        do_reset(2);
        repeat (3) @(negedge clk);

        // Directed corner cases
        issue(16'h0000, 16'h0001, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h0007, 16'h0005, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0);
        issue(16'h000A, 16'h0006, 1'b1, 1'b1);

        // Start pulsed mid-operation is ignored
        issue(16'h1234, 16'h0F0F, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        // Reset in the middle of an operation aborts it
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset(2);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);

        // Randomized traffic, mixing back-to-back and spaced starts
        for (int i = 0; i < 40; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands through a single CHUNK-bit ripple-carry stage, processing one chunk per clock, LSB chunk first. It generalises the 4-bit ripple-carry adder:
- width, via parameters;
- add/subtract mode;
- carry/borrow-in;
- signed overflow;
- a start/busy/done handshake.

It sits in the datapath wherever a wide add is needed but area must stay at one small adder slice.

## Interface
- WIDTH, 16, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. N = WIDTH/CHUNK (N ≥ 1).

- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only while busy = 0.
- sub  input  1  mode; 0 = A + B + cin, 1 = A − B − cin (cin acts as borrow-in). Latched with start.
- a  input  WIDTH  operand A, latched with start.
- b  input  WIDTH  operand B, latched with start.
- cin  input  1  carry-in (add) or borrow-in (sub), latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- States: IDLE, RUN.
- Reset: state IDLE; busy, done, sum, cout, ovf all 0; internal registers cleared.
- IDLE, start = 1 at an edge:
  - latch a, b, sub, cin;
  - chunk counter ← 0;
  - carry register ← (sub ? ~cin : cin);
  - effective B ← (sub ? ~b : b);
  - busy ← 1; go to RUN.
- RUN, each edge:
  - add chunk i of A, chunk i of effective B and the carry register;
  - write the CHUNK-bit result into bits [i·CHUNK +: CHUNK] of an internal accumulator;
  - carry register ← chunk carry-out;
  - counter ← counter + 1.
- Final chunk (i = N−1), same edge:
  - sum ← full accumulator, including the final chunk;
  - cout ← chunk carry-out;
  - ovf ← carry into MSB XOR carry out of MSB;
  - done ← 1, busy ← 0, go to IDLE.
- sum, cout and ovf change only at completion and hold until the next completion or reset. Intermediate chunk results never appear on sum.
- done is high for exactly one cycle and is otherwise 0.
- start while busy = 1 is ignored. Operands are not re-sampled mid-operation.
- rst during RUN aborts immediately: no done pulse, outputs return to reset values.
- N = 1 (CHUNK = WIDTH): RUN lasts one cycle, giving a single-cycle full-width add.
- Counter width is max(1, ceil(log2 N)).

## Timing
- Start accepted at edge k. busy is high after edge k.
- Chunk j is computed at edge k+1+j.
- The final chunk is at edge k+N. After edge k+N: done = 1, busy = 0, sum/cout/ovf valid.
- Latency: N cycles from the accepting edge to the result being visible.
- Earliest next accepted start is edge k+N+1, the cycle in which done is high. That start is accepted, giving a throughput of one operation per N+1 cycles.
- Carry propagates through only CHUNK bits per cycle. The critical path is one CHUNK-bit ripple plus the register.

## Test plan
WIDTH = 16, CHUNK = 4, so N = 4.
- Reset: assert rst for 2 cycles with random inputs → busy, done, sum, cout, ovf all 0. Release rst with start = 0 → outputs stay 0.
- Add 0x0000 + 0x0001, cin = 0, sub = 0 → exactly 4 edges after start, done = 1 for one cycle, sum = 0x0001, cout = 0, ovf = 0. Busy is high for those 4 cycles.
- Full carry ripple: 0xFFFF + 0x0001, cin = 0 → sum = 0x0000, cout = 1, ovf = 0. Signed overflow: 0x7FFF + 0x0001 → sum = 0x8000, cout = 0, ovf = 1. Carry-in: 0x0007 + 0x0005, cin = 1 → sum = 0x000D.
- Subtract: 0x0005 − 0x0007, cin = 0 → sum = 0xFFFE, cout = 0 (borrow), ovf = 0. Then 0x8000 − 0x0001 → sum = 0x7FFF, cout = 1, ovf = 1. Then 0x000A − 0x0006, cin = 1 → sum = 0x0003.
- Handshake:
  - Pulse start again at edge k+2 with different operands → ignored; the result is that of the first operands.
  - Start held in the done cycle → accepted, second done at edge k+2N+1.
  - sum stays stable between dones.
- Reset mid-operation: start 0x1234 + 0x1111, assert rst at edge k+2 → no done pulse, sum = 0, busy = 0. A new start after release completes normally, giving 0x2345.
